// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush responder for the ID-stage hazard flags, with a
// req/ack/done handshake toward the AES128 coprocessor and saturating
// stall/flush statistics.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; hazards resolved by stall or flush
// AES_REQ  | pipeline held, request raised, waiting for ack
// AES_BUSY | pipeline held, request accepted, waiting for done
module pipe_stall_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_data_hazard,
    input  logic             in_ctrl_hazard,
    input  logic             in_aes_start,
    input  logic             in_aes_ack,
    input  logic             in_aes_done,
    output logic             out_PC_wr_en,
    output logic             out_IFID_wr_en,
    output logic             out_IFID_flush,
    output logic             out_IDEX_flush,
    output logic             out_aes_req,
    output logic             out_aes_err,
    output logic [CNT_W-1:0] out_stall_cnt,
    output logic [CNT_W-1:0] out_flush_cnt
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        AES_REQ  = 2'd1,
        AES_BUSY = 2'd2
    } state_t;

    state_t           state;
    logic             grant;
    logic [TW-1:0]    tmo_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             aes_err;

    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_flush;
    logic aes_req;
    logic tmo_last;
    logic aes_take;

    assign tmo_last = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    // A pending AES op is taken only when no hazard outranks it and the
    // previous op has not just completed (grant lets it advance once).
    assign aes_take = !in_ctrl_hazard && !in_data_hazard && in_aes_start && !grant;

    // Pipeline enables/flushes and the AES request, from state and hazard inputs
    always_comb begin
        pc_wr      = 1'b0;
        ifid_wr    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        aes_req    = 1'b0;
        if (!in_rst) begin
            case (state)
                RUN: begin
                    if (in_ctrl_hazard) begin
                        pc_wr      = 1'b1;
                        ifid_wr    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (in_data_hazard || aes_take) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_wr   = 1'b1;
                        ifid_wr = 1'b1;
                    end
                end
                AES_REQ: begin
                    aes_req    = 1'b1;
                    idex_flush = 1'b1;
                end
                AES_BUSY: begin
                    idex_flush = 1'b1;
                end
                default: begin
                    idex_flush = 1'b0;
                end
            endcase
        end
    end

    // Handshake FSM with abort on timeout, plus saturating statistics
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state     <= RUN;
            grant     <= 1'b0;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            aes_err   <= 1'b0;
        end else begin
            aes_err <= 1'b0;
            case (state)
                RUN: begin
                    grant <= 1'b0;
                    if (aes_take) begin
                        state   <= AES_REQ;
                        tmo_cnt <= '0;
                    end
                end
                AES_REQ: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if ((in_aes_ack && in_aes_done) || tmo_last) begin
                        state   <= RUN;
                        grant   <= 1'b1;
                        aes_err <= tmo_last && !in_aes_done;
                    end else if (in_aes_ack) begin
                        state <= AES_BUSY;
                    end
                end
                AES_BUSY: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (in_aes_done || tmo_last) begin
                        state   <= RUN;
                        grant   <= 1'b1;
                        aes_err <= tmo_last && !in_aes_done;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
            if (!pc_wr && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign out_PC_wr_en   = pc_wr;
    assign out_IFID_wr_en = ifid_wr;
    assign out_IFID_flush = ifid_flush;
    assign out_IDEX_flush = idex_flush;
    assign out_aes_req    = aes_req;
    assign out_aes_err    = aes_err;
    assign out_stall_cnt  = stall_cnt;
    assign out_flush_cnt  = flush_cnt;

endmodule
